// File: rtl/thor2023_ic_refill_pkg.sv
// rtl/thor2023_ic_refill_pkg.sv - shared types and line geometry for the I-cache refill controller
package Thor2023Pkg;

  // Refill controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } ic_refill_state_t;

  localparam int ICACHE_LINE_BITS = 512;
  localparam int ICACHE_BEATS     = 4;

endpackage

// File: rtl/thor2023_ic_waysel.sv
// rtl/thor2023_ic_waysel.sv - replacement way selector (round-robin, or LFSR when THOR2023_IC_LFSR_EN is defined)
module thor2023_ic_waysel (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  output logic [1:0] way
);

`ifdef THOR2023_IC_LFSR_EN
  logic [15:0] lfsr;
  // The LFSR free-runs; accepted misses do not influence it
  logic        unused_adv;
  assign unused_adv = adv;

  // 16-bit maximal Fibonacci LFSR, taps 16,14,13,11, stepped every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 16'h0001;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign way = lfsr[1:0];
`else
  logic [1:0] cnt;

  // Round-robin counter, advanced once per accepted miss
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= 2'd0;
    else if (adv) cnt <= cnt + 2'd1;
  end

  assign way = cnt;
`endif

endmodule

// File: rtl/thor2023_ic_refill.sv
// rtl/thor2023_ic_refill.sv - I-cache miss/refill controller; THOR2023_IC_LFSR_EN selects LFSR replacement
module thor2023_ic_refill
  import Thor2023Pkg::*;
#(
  parameter int LINES     = 256,
  parameter int WAYS      = 4,
  parameter int AWID      = 32,
  parameter int TAGBIT    = 14,
  parameter int BUSW      = 128,
  parameter int LINEBYTES = ICACHE_LINE_BITS / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_req,
  input  logic [AWID-1:0]            miss_adr,
  input  logic                       invall,
  input  logic                       invline,
  input  logic [AWID-1:0]            inv_adr,
  output logic                       busy,
  output logic                       m_cyc,
  output logic                       m_stb,
  output logic [AWID-1:0]            m_adr,
  input  logic                       m_ack,
  input  logic                       m_err,
  input  logic [BUSW-1:0]            m_dat_i,
  output logic                       wr,
  output logic [1:0]                 wr_way,
  output logic [$clog2(LINES)-1:0]   wr_ndx,
  output logic [AWID-TAGBIT-1:0]     wr_tag,
  output logic [LINEBYTES*8-1:0]     wr_data,
  output logic [LINES-1:0]           valid [0:WAYS-1],
  output logic                       done,
  output logic                       err
);

  localparam int NDXW  = $clog2(LINES);
  localparam int BEATS = LINEBYTES * 8 / BUSW;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFW  = $clog2(LINEBYTES);

  ic_refill_state_t state, state_nxt;
  logic [BW-1:0]    beat;
  logic             accept;
  logic [1:0]       sel_way;
  logic [NDXW-1:0]  inv_ndx;
  logic             unused_bits;

  assign inv_ndx     = inv_adr[TAGBIT-1 -: NDXW];
  assign busy        = (state != IDLE);
  assign unused_bits = ^{miss_adr[OFFW-1:0], inv_adr[AWID-1:TAGBIT], inv_adr[TAGBIT-NDXW-1:0]};

  thor2023_ic_waysel u_waysel (
    .clk (clk),
    .rst (rst),
    .adv (accept),
    .way (sel_way)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; a bus error aborts the fetch regardless of ack
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (miss_req) begin
          accept    = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (m_err)                                   state_nxt = IDLE;
        else if (m_ack && beat == BW'(BEATS - 1))    state_nxt = WRITE;
      end
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus master, line assembly and registered write/status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc   <= 1'b0;
      m_stb   <= 1'b0;
      m_adr   <= '0;
      beat    <= '0;
      wr      <= 1'b0;
      wr_way  <= 2'd0;
      wr_ndx  <= '0;
      wr_tag  <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      wr   <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      if (accept) begin
        m_cyc  <= 1'b1;
        m_stb  <= 1'b1;
        m_adr  <= {miss_adr[AWID-1:OFFW], {OFFW{1'b0}}};
        beat   <= '0;
        wr_way <= sel_way;
        wr_ndx <= miss_adr[TAGBIT-1 -: NDXW];
        wr_tag <= miss_adr[AWID-1:TAGBIT];
      end
      if (state == FETCH) begin
        if (m_err) begin
          m_cyc <= 1'b0;
          m_stb <= 1'b0;
          err   <= 1'b1;
        end else if (m_ack) begin
          wr_data[int'(beat)*BUSW +: BUSW] <= m_dat_i;
          beat <= beat + 1'b1;
          if (beat == BW'(BEATS - 1)) begin
            m_cyc <= 1'b0;
            m_stb <= 1'b0;
            wr    <= 1'b1;
            done  <= 1'b1;
          end else begin
            m_adr <= m_adr + AWID'(BUSW / 8);
          end
        end
      end
    end
  end

  // Valid arrays; invalidation is applied last so it beats a same-edge fill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) valid[w] <= '0;
    end else if (invall) begin
      for (int w = 0; w < WAYS; w++) valid[w] <= '0;
    end else begin
      if (state == WRITE) valid[wr_way][wr_ndx] <= 1'b1;
      if (invline) begin
        for (int w = 0; w < WAYS; w++) valid[w][inv_ndx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_thor2023_ic_refill.sv
// tb/tb_thor2023_ic_refill.sv - scoreboard bench for the I-cache refill controller
module tb_thor2023_ic_refill;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         miss_req = 1'b0;
  logic [31:0]  miss_adr = '0;
  logic         invall = 1'b0;
  logic         invline = 1'b0;
  logic [31:0]  inv_adr = '0;
  logic         busy, m_cyc, m_stb;
  logic [31:0]  m_adr;
  logic         m_ack = 1'b0;
  logic         m_err = 1'b0;
  logic [127:0] m_dat_i = '0;
  logic         wr;
  logic [1:0]   wr_way;
  logic [7:0]   wr_ndx;
  logic [17:0]  wr_tag;
  logic [511:0] wr_data;
  logic [255:0] valid [0:3];
  logic         done, err;

  thor2023_ic_refill dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_adr(miss_adr),
    .invall(invall), .invline(invline), .inv_adr(inv_adr), .busy(busy),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_adr(m_adr), .m_ack(m_ack), .m_err(m_err),
    .m_dat_i(m_dat_i), .wr(wr), .wr_way(wr_way), .wr_ndx(wr_ndx), .wr_tag(wr_tag),
    .wr_data(wr_data), .valid(valid), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   way;
    logic [7:0]   ndx;
    logic [17:0]  tag;
    logic [511:0] data;
  } wr_exp_t;

  logic [31:0]  bus_q [$];
  wr_exp_t      wr_q [$];
  int           err_exp = 0;
  int           err_at = -1;
  int           checks = 0;
  int           errors = 0;
  logic [1:0]   rr = 2'd0;
  logic [255:0] exp_valid [0:3];
  bit [3:0]     ways_seen = '0;

`ifdef THOR2023_IC_LFSR_EN
  logic [15:0] mlfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) mlfsr <= 16'h0001;
    else     mlfsr <= {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
  end
`endif

  function automatic logic [127:0] beat_data(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, a + 32'd1, ~a, a};
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic chk_valid(input string name);
    for (int w = 0; w < 4; w++) chk(name, {256'd0, valid[w]}, {256'd0, exp_valid[w]});
  endtask

  // Zero-wait slave; errors on the selected beat when err_at >= 0
  always @(negedge clk) begin
    m_ack   = m_cyc;
    m_err   = m_cyc && (err_at >= 0) && (int'(m_adr[5:4]) == err_at);
    m_dat_i = beat_data(m_adr);
  end

  // Monitor: pops expectations whenever the DUT presents bus beats, writes or errors
  always @(negedge clk) begin
    if (!rst) begin
      if (m_cyc) begin
        if (bus_q.size() == 0) chk("bus_unexpected", 1, 0);
        else begin
          chk("m_adr", m_adr, bus_q.pop_front());
          chk("m_stb", m_stb, 1);
        end
      end
      if (wr) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          chk("wr_way", wr_way, e.way);
          chk("wr_ndx", wr_ndx, e.ndx);
          chk("wr_tag", wr_tag, e.tag);
          chk("wr_data", wr_data, e.data);
          chk("done_with_wr", done, 1);
        end
      end else if (done) chk("done_without_wr", 1, 0);
      if (err) begin
        if (err_exp == 0) chk("err_unexpected", 1, 0);
        else begin
          err_exp--;
          chk("busy_at_err", busy, 0);
        end
      end
    end
  end

  function automatic logic [1:0] exp_way_now();
`ifdef THOR2023_IC_LFSR_EN
    return mlfsr[1:0];
`else
    return rr;
`endif
  endfunction

  // Issue one miss (called and returns at a falling edge)
  task automatic do_miss(input logic [31:0] adr, input int err_beat, input bit inv_wr);
    logic [1:0]   w;
    logic [31:0]  base;
    logic [511:0] d;
    int           cyc;
    bit           seen;
    wr_exp_t      e;
    base = {adr[31:6], 6'd0};
    w    = exp_way_now();
    ways_seen[w] = 1'b1;
    d = '0;
    for (int k = 0; k < 4; k++) begin
      if (err_beat < 0 || k <= err_beat) bus_q.push_back(base + 32'(16 * k));
      d[k*128 +: 128] = beat_data(base + 32'(16 * k));
    end
    if (err_beat < 0) begin
      e.way = w; e.ndx = adr[13:6]; e.tag = adr[31:14]; e.data = d;
      wr_q.push_back(e);
    end else err_exp++;
    err_at   = err_beat;
    miss_adr = adr;
    miss_req = 1'b1;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      miss_req = 1'b0;
      if (wr || err) seen = 1;
    end
    chk("refill_seen", seen, 1);
    if (err_beat < 0) begin
      chk("wr_latency", cyc, 5);
      if (inv_wr) begin
        invline = 1'b1;
        inv_adr = adr;
      end else exp_valid[w][adr[13:6]] = 1'b1;
    end
    rr = rr + 2'd1;
    @(posedge clk);
    @(negedge clk);
    invline = 1'b0;
    err_at  = -1;
    chk("busy_after", busy, 0);
  endtask

  initial begin
    for (int w = 0; w < 4; w++) exp_valid[w] = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_bus", {m_cyc, m_stb, m_adr}, 0);
    chk("rst_wr", {wr, done, err, wr_way, wr_ndx, wr_tag}, 0);
    chk("rst_wr_data", wr_data, 0);
    chk_valid("rst_valid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic refill and four ways at one index
    do_miss(32'h0000_4A7C, -1, 0);
    chk_valid("valid_first");
    do_miss(32'h0000_8A40, -1, 0);
    do_miss(32'h0000_CA40, -1, 0);
    do_miss(32'h0001_0A40, -1, 0);
    chk_valid("valid_four");
`ifndef THOR2023_IC_LFSR_EN
    for (int w = 0; w < 4; w++) chk("valid_way_29", valid[w][8'h29], 1);
`endif

    // Bus error on beat 2
    do_miss(32'h0000_1230, 2, 0);
    chk_valid("valid_after_err");

    // Invalidate the line in its WRITE cycle
    do_miss(32'h0000_2000, -1, 1);
    chk_valid("valid_inv_in_write");

    // Global invalidate
    invall = 1'b1;
    @(negedge clk);
    invall = 1'b0;
    for (int w = 0; w < 4; w++) exp_valid[w] = '0;
    do_miss(32'h0000_5040, -1, 0);
    chk_valid("valid_after_invall");

    // Reset in the middle of beat 1
    bus_q.push_back(32'h0000_3000);
    bus_q.push_back(32'h0000_3010);
    miss_adr = 32'h0000_3000;
    miss_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    miss_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_cyc", {m_cyc, m_stb}, 0);
    chk("rst_mid_busy", busy, 0);
    for (int w = 0; w < 4; w++) exp_valid[w] = '0;
    chk_valid("rst_mid_valid");
    bus_q.delete();
    wr_q.delete();
    err_exp = 0;
    rr = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_miss(32'h0000_3000, -1, 0);
    chk_valid("valid_after_rst");

`ifdef THOR2023_IC_LFSR_EN
    ways_seen = '0;
    for (int i = 0; i < 64; i++) do_miss(32'h0002_0000 + 32'(i * 64), -1, 0);
    chk_valid("valid_lfsr");
    chk("lfsr_all_ways", ways_seen, 4'hF);
`endif

    repeat (3) @(negedge clk);
    chk("bus_q_empty", bus_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("err_q_empty", err_exp, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
